// File: rtl/sys_defs.sv
// Shared definitions for the functional units: issue packets, multiplier encodings and
// the per-stage multiplier state carried down the pipe.
package sys_defs;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned ROB_IDX_W   = 5;
  localparam int unsigned PRN_W       = 6;
  localparam int unsigned NUM_FU_MULT = 2;

  typedef enum logic [1:0] {
    M_MUL    = 2'h0,
    M_MULH   = 2'h1,
    M_MULHSU = 2'h2,
    M_MULHU  = 2'h3
  } MULT_FUNC;

  typedef struct packed {
    logic                 valid;
    MULT_FUNC             func;
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic [PRN_W-1:0]     dest_prn;
    logic [ROB_IDX_W-1:0] robn;
  } FU_PACKET;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] robn;
    logic [PRN_W-1:0]     dest_prn;
    logic [XLEN-1:0]      result;
  } FU_MULT_PACKET;

  typedef struct packed {
    logic                 valid;
    MULT_FUNC             func;
    logic [ROB_IDX_W-1:0] robn;
    logic [PRN_W-1:0]     dest_prn;
    logic [63:0]          mcand;
    logic [63:0]          mplier;
    logic [63:0]          acc;
  } MULT_STAGE_PACKET;

endpackage

// File: rtl/mult_stage.sv
// One partial-product step: folds the low 64/NUM_STAGES multiplier bits into the
// accumulator, then shifts multiplicand/multiplier for the next step.
module mult_stage
  import sys_defs::*;
#(
  parameter int unsigned NUM_STAGES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hold,
  input  logic             flush,
  input  MULT_STAGE_PACKET stage_in,
  output MULT_STAGE_PACKET stage_out
);

  localparam int unsigned BITS = 64 / NUM_STAGES;

  MULT_STAGE_PACKET stage_next;
  logic [63:0]      mplier_slice;

  always_comb begin
    mplier_slice      = {{(64 - BITS){1'b0}}, stage_in.mplier[BITS-1:0]};
    stage_next        = stage_in;
    stage_next.acc    = stage_in.acc + stage_in.mcand * mplier_slice;
    stage_next.mcand  = stage_in.mcand << BITS;
    stage_next.mplier = stage_in.mplier >> BITS;
  end

  // Flush wins over hold so a squash always empties a stalled pipe.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      stage_out <= '0;
    end else if (!hold) begin
      stage_out <= stage_next;
    end
  end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined 32x32 multiplier (MUL/MULH/MULHSU/MULHU) with NUM_STAGES-cycle latency,
// full throughput, back-pressure from the CDB ack, and squash.
module mult_pipe
  import sys_defs::*;
#(
  parameter int unsigned NUM_STAGES = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  FU_PACKET      fu_packet,
  input  logic          squash,
  input  logic          ack,
  output logic          avail,
  output logic          prep,
  output FU_MULT_PACKET mult_packet
);

  MULT_STAGE_PACKET first_in;
  MULT_STAGE_PACKET stage_out [NUM_STAGES];
  MULT_STAGE_PACKET last;
  logic             stall;
  logic             sign1;
  logic             sign2;
  logic             unused_last;

  assign last  = stage_out[NUM_STAGES-1];
  assign prep  = last.valid;
  assign stall = prep & ~ack;
  assign avail = ~stall;

  assign unused_last = ^{last.mcand, last.mplier};

  always_comb begin
    sign1    = (fu_packet.func != M_MULHU);
    sign2    = (fu_packet.func == M_MUL) || (fu_packet.func == M_MULH);
    first_in = '0;
    if (fu_packet.valid && avail) begin
      first_in.valid    = 1'b1;
      first_in.func     = fu_packet.func;
      first_in.robn     = fu_packet.robn;
      first_in.dest_prn = fu_packet.dest_prn;
      first_in.mcand    = {{32{sign1 & fu_packet.op1[31]}}, fu_packet.op1};
      first_in.mplier   = {{32{sign2 & fu_packet.op2[31]}}, fu_packet.op2};
    end
  end

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      mult_stage #(
        .NUM_STAGES(NUM_STAGES)
      ) u_stage (
        .clock    (clock),
        .reset    (reset),
        .hold     (stall),
        .flush    (squash),
        .stage_in (first_in),
        .stage_out(stage_out[i])
      );
    end else begin : g_body
      mult_stage #(
        .NUM_STAGES(NUM_STAGES)
      ) u_stage (
        .clock    (clock),
        .reset    (reset),
        .hold     (stall),
        .flush    (squash),
        .stage_in (stage_out[i-1]),
        .stage_out(stage_out[i])
      );
    end
  end

  always_comb begin
    mult_packet = '0;
    if (prep) begin
      mult_packet.robn     = last.robn;
      mult_packet.dest_prn = last.dest_prn;
      mult_packet.result   = (last.func == M_MUL) ? last.acc[31:0] : last.acc[63:32];
    end
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Bench for mult_pipe: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a queue-based model of the unit.
module tb_mult_pipe;
  import sys_defs::*;

  localparam int unsigned NS = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          squash;
  logic          ack;
  logic          avail;
  logic          prep;
  FU_PACKET      fu_packet;
  FU_MULT_PACKET mult_packet;

  always #5 clock = ~clock;

  mult_pipe #(
    .NUM_STAGES(NS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .fu_packet  (fu_packet),
    .squash     (squash),
    .ack        (ack),
    .avail      (avail),
    .prep       (prep),
    .mult_packet(mult_packet)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Each in-flight op with the number of edges it has advanced through.
  typedef struct {
    FU_MULT_PACKET pkt;
    int            age;
  } ent_t;
  ent_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(MULT_FUNC f, logic [31:0] a, logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      M_MUL, M_MULH: p = sa * sb;
      M_MULHSU:      p = sa * ub;
      default:       p = ua * ub;
    endcase
    return (f == M_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic FU_PACKET mk(logic v, MULT_FUNC f, logic [31:0] a, logic [31:0] b,
                                  int robn, int prn);
    FU_PACKET p;
    p.valid    = v;
    p.func     = f;
    p.op1      = a;
    p.op2      = b;
    p.robn     = ROB_IDX_W'(robn);
    p.dest_prn = PRN_W'(prn);
    return p;
  endfunction

  function automatic logic m_prep();
    return (q.size() > 0) && (q[0].age == NS);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_outputs();
    FU_MULT_PACKET exp_pkt;
    exp_pkt = m_prep() ? q[0].pkt : '0;
    chk("prep", {63'b0, prep}, {63'b0, m_prep()});
    chk("avail", {63'b0, avail}, {63'b0, !(m_prep() && !ack)});
    chk("mult_packet", 64'(mult_packet), 64'(exp_pkt));
  endtask

  task automatic model_step();
    logic p;
    ent_t e;
    p = m_prep();
    if (reset || squash) begin
      q.delete();
    end else if (!(p && !ack)) begin
      if (p) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (fu_packet.valid) begin
        e.pkt.robn     = fu_packet.robn;
        e.pkt.dest_prn = fu_packet.dest_prn;
        e.pkt.result   = ref_result(fu_packet.func, fu_packet.op1, fu_packet.op2);
        e.age          = 1;
        q.push_back(e);
      end
    end
  endtask

  // Drive one cycle's inputs, compare, then advance the model across the edge.
  task automatic cycle(input FU_PACKET p, input logic a, input logic s, input logic r);
    fu_packet = p;
    ack       = a;
    squash    = s;
    reset     = r;
    #1;
    check_outputs();
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    FU_PACKET idle;
    idle      = '0;
    fu_packet = '0;
    ack       = 1'b0;
    squash    = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    q.delete();
    reset = 1'b0;
    #1;
    chk("reset_prep", {63'b0, prep}, 64'd0);
    chk("reset_avail", {63'b0, avail}, 64'd1);
    chk("reset_pkt", 64'(mult_packet), 64'd0);

    // Pin the model with hand-computed products.
    chk("model_mulh", {32'b0, ref_result(M_MULH, 32'h8000_0000, 32'h8000_0000)}, 64'h4000_0000);
    chk("model_mulhu", {32'b0, ref_result(M_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF)},
        64'hFFFF_FFFE);
    chk("model_mulhsu", {32'b0, ref_result(M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF)},
        64'hFFFF_FFFF);
    chk("model_mul", {32'b0, ref_result(M_MUL, 32'hFFFF_FFFF, 32'h2)}, 64'hFFFF_FFFE);

    // Latency: 5*5 appears exactly NS cycles after issue.
    cycle(mk(1'b1, M_MUL, 32'd5, 32'd5, 1, 1), 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      chk("lat_prep", {63'b0, prep}, {63'b0, k == 4});
      chk("lat_avail", {63'b0, avail}, 64'd1);
      if (k == 4) begin
        chk("lat_result", {32'b0, mult_packet.result}, 64'd25);
        chk("lat_robn", {59'b0, mult_packet.robn}, 64'd1);
        chk("lat_prn", {58'b0, mult_packet.dest_prn}, 64'd1);
      end
      cycle(idle, 1'b1, 1'b0, 1'b0);
    end

    // Signedness, issued back to back so results must also come out consecutively.
    cycle(mk(1'b1, M_MULH, 32'h8000_0000, 32'h8000_0000, 0, 10), 1'b1, 1'b0, 1'b0);
    cycle(mk(1'b1, M_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 11), 1'b1, 1'b0, 1'b0);
    cycle(mk(1'b1, M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 12), 1'b1, 1'b0, 1'b0);
    cycle(mk(1'b1, M_MUL, 32'hFFFF_FFFF, 32'h2, 3, 13), 1'b1, 1'b0, 1'b0);
    begin
      logic [31:0] sgn_exp [4];
      sgn_exp[0] = 32'h4000_0000;
      sgn_exp[1] = 32'hFFFF_FFFE;
      sgn_exp[2] = 32'hFFFF_FFFF;
      sgn_exp[3] = 32'hFFFF_FFFE;
      for (int k = 0; k < 4; k++) begin
        chk("sgn_prep", {63'b0, prep}, 64'd1);
        chk("sgn_result", {32'b0, mult_packet.result}, {32'b0, sgn_exp[k]});
        chk("sgn_robn", {59'b0, mult_packet.robn}, 64'(k));
        cycle(idle, 1'b1, 1'b0, 1'b0);
      end
      chk("sgn_done", {63'b0, prep}, 64'd0);
    end

    // Stall: three MULs, ack held low once the first is ready.
    cycle(mk(1'b1, M_MUL, 32'd3, 32'd7, 5, 20), 1'b0, 1'b0, 1'b0);
    cycle(mk(1'b1, M_MUL, 32'd4, 32'd7, 6, 21), 1'b0, 1'b0, 1'b0);
    cycle(mk(1'b1, M_MUL, 32'd5, 32'd7, 7, 22), 1'b0, 1'b0, 1'b0);
    cycle(idle, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("stall_prep", {63'b0, prep}, 64'd1);
      chk("stall_avail", {63'b0, avail}, 64'd0);
      chk("stall_pkt", 64'(mult_packet), {21'b0, 5'd5, 6'd20, 32'd21});
      cycle(idle, 1'b0, 1'b0, 1'b0);
    end
    chk("drain0", {32'b0, mult_packet.result}, 64'd21);
    cycle(idle, 1'b1, 1'b0, 1'b0);
    chk("drain1", {32'b0, mult_packet.result}, 64'd28);
    cycle(idle, 1'b1, 1'b0, 1'b0);
    chk("drain2", {32'b0, mult_packet.result}, 64'd35);
    cycle(idle, 1'b1, 1'b0, 1'b0);
    chk("drain_done", {63'b0, prep}, 64'd0);

    // Squash with two in flight and a valid packet offered the same cycle.
    cycle(mk(1'b1, M_MUL, 32'd2, 32'd9, 1, 30), 1'b1, 1'b0, 1'b0);
    cycle(mk(1'b1, M_MUL, 32'd3, 32'd9, 2, 31), 1'b1, 1'b0, 1'b0);
    cycle(mk(1'b1, M_MUL, 32'd4, 32'd9, 3, 32), 1'b1, 1'b1, 1'b0);
    chk("squash_avail", {63'b0, avail}, 64'd1);
    for (int k = 0; k < 6; k++) begin
      chk("squash_prep", {63'b0, prep}, 64'd0);
      cycle(idle, 1'b1, 1'b0, 1'b0);
    end

    // Reset while stalled.
    cycle(mk(1'b1, M_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 9, 40), 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(idle, 1'b0, 1'b0, 1'b0);
    chk("rst_stalled", {63'b0, avail}, 64'd0);
    cycle(idle, 1'b0, 1'b0, 1'b1);
    chk("rst_prep", {63'b0, prep}, 64'd0);
    chk("rst_pkt", 64'(mult_packet), 64'd0);
    chk("rst_avail", {63'b0, avail}, 64'd1);

    // Randomized traffic with back-pressure, squashes and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      cycle(mk($urandom_range(0, 9) < 7, MULT_FUNC'($urandom_range(0, 3)), pick(), pick(),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 63))),
            $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, $urandom_range(0, 199) < 1);
    end
    repeat (NS + 2) cycle(idle, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
